// File: rtl/nway_cache_ctrl.sv
// N-way set-associative write-back cache controller.
// A single FSM serves one CPU access at a time. On a miss it writes back a
// dirty victim line and refills the line from memory one word per beat.
// Victims are chosen by true-LRU: every set keeps a permutation of ages.
module nway_cache_ctrl #(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [2:0]           cpu_u_b_h_w,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [31:0]          cpu_din,
    output logic                 cpu_ready,
    output logic                 cpu_hit,
    output logic [31:0]          cpu_dout,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_dout,
    input  logic [31:0]          mem_din,
    input  logic                 mem_ack
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_BITS - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    state_t state;
    logic [OFF_W-1:0] cnt;
    logic             miss;
    logic [WAY_W-1:0] victim;

    // Latched request (data side; only meaningful after IDLE accepts a request)
    logic [ADDR_BITS-1:0] req_addr;
    logic                 req_we;
    logic [2:0]           req_size;
    logic [31:0]          req_din;

    // Cache storage
    logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
    logic [31:0]      data_mem [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]  valid    [SETS];
    logic [WAYS-1:0]  dirty    [SETS];
    logic [WAY_W-1:0] age      [SETS][WAYS];

    // Request address fields
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [1:0]       req_byte;
    logic [OFF_W-1:0] cnt_nx;

    assign req_tag  = req_addr[ADDR_BITS-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W+2 +: IDX_W];
    assign req_off  = req_addr[2 +: OFF_W];
    assign req_byte = req_addr[1:0];
    assign cnt_nx   = cnt + 1'b1;

    // Lookup results
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vic_way;
    logic             vic_free;
    logic [31:0]      hit_word;
    logic [WAY_W-1:0] hit_age;

    // Extend a loaded byte/half/word according to the RV32I load type.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (size[1])
            res = word;
        else if (size[0])
            res = size[2] ? {16'h0000, h} : {{16{h[15]}}, h};
        else
            res = size[2] ? {24'h000000, b} : {{24{b[7]}}, b};
        return res;
    endfunction

    // Merge low-aligned store data into the byte lanes picked by offset and size.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] din,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
        logic [31:0] res;
        res = old;
        if (size[1]) begin
            res = din;
        end else if (size[0]) begin
            if (off[1]) res[31:16] = din[15:0];
            else        res[15:0]  = din[15:0];
        end else begin
            res[{off, 3'b000} +: 8] = din[7:0];
        end
        return res;
    endfunction

    // Tag compare over the indexed set and victim selection for a miss
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        vic_way  = '0;
        vic_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
            if (hit_vec[w]) hit_way = w[WAY_W-1:0];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                vic_way  = w[WAY_W-1:0];
                vic_free = 1'b1;
            end
        end
        if (!vic_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[req_idx][w] == OLDEST) vic_way = w[WAY_W-1:0];
            end
        end
    end

    assign hit_any  = |hit_vec;
    assign hit_word = data_mem[req_idx][hit_way][req_off];
    assign hit_age  = age[req_idx][hit_way];

    // Request latch and tag/data array writes (not reset)
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            req_addr <= cpu_addr;
            req_we   <= cpu_we;
            req_size <= cpu_u_b_h_w;
            req_din  <= cpu_din;
        end
        if (state == COMPARE && hit_any && req_we)
            data_mem[req_idx][hit_way][req_off] <=
                store_merge(hit_word, req_din, req_byte, req_size);
        if (state == REFILL && mem_ack) begin
            data_mem[req_idx][victim][cnt] <= mem_din;
            if (cnt == LAST_BEAT) tag_mem[req_idx][victim] <= req_tag;
        end
    end

    // Miss FSM, line state (valid/dirty/age) and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            miss      <= 1'b0;
            victim    <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_dout  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= w[WAY_W-1:0];
            end
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        miss  <= 1'b0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit_any) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= !miss;
                        if (req_we)
                            dirty[req_idx][hit_way] <= 1'b1;
                        else
                            cpu_dout <= load_extend(hit_word, req_byte, req_size);
                        for (int w = 0; w < WAYS; w++) begin
                            if (w[WAY_W-1:0] == hit_way)
                                age[req_idx][w] <= '0;
                            else if (age[req_idx][w] < hit_age)
                                age[req_idx][w] <= age[req_idx][w] + 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        miss    <= 1'b1;
                        victim  <= vic_way;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (valid[req_idx][vic_way] && dirty[req_idx][vic_way]) begin
                            mem_we   <= 1'b1;
                            mem_addr <= {tag_mem[req_idx][vic_way], req_idx, {OFF_W{1'b0}}, 2'b00};
                            mem_dout <= data_mem[req_idx][vic_way][0];
                            state    <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            state    <= REFILL;
                        end
                        // The victim line is being replaced; it stays invalid until refilled.
                        valid[req_idx][vic_way] <= 1'b0;
                        dirty[req_idx][vic_way] <= 1'b0;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        if (cnt == LAST_BEAT) begin
                            cnt      <= '0;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            state    <= REFILL;
                        end else begin
                            cnt      <= cnt_nx;
                            mem_addr <= {tag_mem[req_idx][victim], req_idx, cnt_nx, 2'b00};
                            mem_dout <= data_mem[req_idx][victim][cnt_nx];
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (cnt == LAST_BEAT) begin
                            cnt     <= '0;
                            mem_req <= 1'b0;
                            valid[req_idx][victim] <= 1'b1;
                            dirty[req_idx][victim] <= 1'b0;
                            state   <= COMPARE;
                        end else begin
                            cnt      <= cnt_nx;
                            mem_addr <= {req_tag, req_idx, cnt_nx, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nway_cache_ctrl.sv
// Self-checking bench for nway_cache_ctrl: memory responder with optional
// stall, beat log, and a scoreboard of expected CPU responses.
module tb_nway_cache_ctrl;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_u_b_h_w = 3'b000;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [31:0] cpu_dout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    nway_cache_ctrl #(.WAYS(4), .SETS(16), .LINE_WORDS(4), .ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_u_b_h_w(cpu_u_b_h_w),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_dout(cpu_dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Backing memory plus stores the cache may still hold dirty
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] pend [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hC0DE0000 ^ a);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        return pend.exists(wa) ? pend[wa] : mem_rd(wa);
    endfunction

    function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] sz);
        logic [31:0] v;
        if (sz[1]) return w;
        if (sz[0]) begin
            v = (w >> (16 * a[1])) & 32'h0000FFFF;
            if (!sz[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = (w >> (8 * a[1:0])) & 32'h000000FF;
            if (!sz[2] && v[7]) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] st_ref(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (sz[1]) return d;
        if (sz[0]) begin sh = 16 * a[1];   m = 32'h0000FFFF << sh; end
        else       begin sh = 8 * a[1:0]; m = 32'h000000FF << sh; end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    function automatic logic [31:0] mdl(input logic [31:0] a, input logic [2:0] sz);
        return ld_ref(word_at(a), a, sz);
    endfunction

    // Memory responder: acks each beat after 'stall' waiting cycles
    int          stall = 0;
    int          wait_cnt = 0;
    logic [31:0] hold_addr, hold_dout;
    logic        hold_we;
    logic        beat_we_q[$];
    logic [31:0] beat_addr_q[$];
    logic [31:0] beat_data_q[$];

    always @(negedge clk) begin
        if (rst) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt < stall) begin
                if (wait_cnt == 0) begin
                    hold_addr = mem_addr;
                    hold_dout = mem_dout;
                    hold_we   = mem_we;
                end else begin
                    check("stall_addr", mem_addr, hold_addr);
                    check("stall_dout", mem_dout, hold_dout);
                    check("stall_we", {31'b0, mem_we}, {31'b0, hold_we});
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                beat_we_q.push_back(mem_we);
                beat_addr_q.push_back(mem_addr);
                beat_data_q.push_back(mem_dout);
                if (mem_we) mem[mem_addr] = mem_dout;
                mem_din = mem_rd(mem_addr);
                mem_ack = 1'b1;
            end
        end
    end

    // Scoreboard of expected CPU completions
    typedef struct {
        string       tag;
        logic        we;
        logic        hit;
        logic [31:0] dout;
    } exp_t;
    exp_t sb_q[$];
    int   ready_cnt = 0;

    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            exp_t e;
            ready_cnt++;
            if (sb_q.size() == 0) begin
                check("spurious_ready", {31'b0, cpu_ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_hit"}, {31'b0, cpu_hit}, {31'b0, e.hit});
                if (!e.we) check({e.tag, "_dout"}, cpu_dout, e.dout);
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic exp_hit,
                          input logic [31:0] exp_dout, input bit hold, output int lat);
        exp_t e;
        int   n0;
        e.tag = tag; e.we = we; e.hit = exp_hit; e.dout = exp_dout;
        sb_q.push_back(e);
        n0 = ready_cnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_u_b_h_w = sz; cpu_addr = a; cpu_din = d;
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            lat++;
            if (!hold) cpu_req = 1'b0;
            if (ready_cnt != n0) break;
        end
        cpu_req = 1'b0;
        if (ready_cnt == n0) begin
            check({tag, "_timeout"}, ready_cnt - n0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic ld(input string tag, input logic [2:0] sz, input logic [31:0] a,
                      input logic exp_hit, input logic [31:0] exp_dout);
        int lat;
        do_req(tag, 1'b0, sz, a, 32'h0, exp_hit, exp_dout, 1'b0, lat);
    endtask

    task automatic st(input string tag, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_hit);
        int lat;
        pend[a & ~32'h3] = st_ref(word_at(a), a, sz, d);
        do_req(tag, 1'b1, sz, a, d, exp_hit, 32'h0, 1'b0, lat);
    endtask

    task automatic clear_log();
        beat_we_q.delete();
        beat_addr_q.delete();
        beat_data_q.delete();
    endtask

    // Check 'LINE_WORDS' consecutive logged beats starting at index 'first'
    task automatic check_line(input string tag, input int first, input logic we,
                              input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            if (first + i < beat_addr_q.size()) begin
                check({tag, "_addr"}, beat_addr_q[first + i], base + 32'(4 * i));
                check({tag, "_we"}, {31'b0, beat_we_q[first + i]}, {31'b0, we});
            end
        end
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend.delete();
        sb_q.delete();
        clear_log();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          n0;
        logic [31:0] exp_wb[4];

        mem[32'h100] = 32'h00000000;
        repeat (3) @(negedge clk);
        // Reset state of the outputs
        check("rst_ready", {31'b0, cpu_ready}, 32'd0);
        check("rst_hit", {31'b0, cpu_hit}, 32'd0);
        check("rst_dout", cpu_dout, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // T1 cold miss then hit
        clear_log();
        ld("t1_miss", SZ_W, 32'h104, 1'b0, mdl(32'h104, SZ_W));
        check("t1_nbeats", beat_addr_q.size(), 32'd4);
        check_line("t1_refill", 0, 1'b0, 32'h100);
        do_req("t1_hit", 1'b0, SZ_W, 32'h104, 32'h0, 1'b1, mdl(32'h104, SZ_W), 1'b0, lat);
        check("t1_latency", lat, 32'd2);

        // T2 sub-word accesses on the cached line 0x100
        st("t2_sb", SZ_B, 32'h103, 32'h123456AB, 1'b1);
        ld("t2_lb", SZ_B, 32'h103, 1'b1, 32'hFFFFFFAB);
        ld("t2_lbu", SZ_BU, 32'h103, 1'b1, 32'h000000AB);
        ld("t2_lh", SZ_H, 32'h102, 1'b1, 32'hFFFFAB00);
        ld("t2_lh_odd", SZ_H, 32'h103, 1'b1, 32'hFFFFAB00);
        ld("t2_lhu", SZ_HU, 32'h103, 1'b1, 32'h0000AB00);
        ld("t2_lw", SZ_W, 32'h100, 1'b1, 32'hAB000000);
        ld("t2_lw_unal", SZ_W, 32'h107, 1'b1, 32'hC0DE0104);
        ld("t2_lh_hi", SZ_H, 32'h106, 1'b1, 32'hFFFFC0DE);
        st("t2_sh", SZ_H, 32'h10A, 32'h00008001, 1'b1);
        ld("t2_lw_sh", SZ_W, 32'h108, 1'b1, mdl(32'h108, SZ_W));

        // T3 LRU replacement in set 0
        do_reset();
        ld("t3_a", SZ_W, 32'h100, 1'b0, mdl(32'h100, SZ_W));
        ld("t3_b", SZ_W, 32'h200, 1'b0, mdl(32'h200, SZ_W));
        ld("t3_c", SZ_W, 32'h300, 1'b0, mdl(32'h300, SZ_W));
        ld("t3_d", SZ_W, 32'h400, 1'b0, mdl(32'h400, SZ_W));
        ld("t3_a_touch", SZ_W, 32'h104, 1'b1, mdl(32'h104, SZ_W));
        clear_log();
        ld("t3_e", SZ_W, 32'h500, 1'b0, mdl(32'h500, SZ_W));
        check("t3_e_nbeats", beat_addr_q.size(), 32'd4);
        check_line("t3_e_refill", 0, 1'b0, 32'h500);
        clear_log();
        ld("t3_b_again", SZ_W, 32'h208, 1'b0, mdl(32'h208, SZ_W));
        check("t3_b_nbeats", beat_addr_q.size(), 32'd4);
        check_line("t3_b_refill", 0, 1'b0, 32'h200);
        ld("t3_a_hit", SZ_W, 32'h10C, 1'b1, mdl(32'h10C, SZ_W));
        ld("t3_d_hit", SZ_W, 32'h404, 1'b1, mdl(32'h404, SZ_W));
        ld("t3_e_hit", SZ_W, 32'h50C, 1'b1, mdl(32'h50C, SZ_W));
        ld("t3_c_miss", SZ_W, 32'h300, 1'b0, mdl(32'h300, SZ_W));

        // T4 dirty eviction with write-back
        do_reset();
        st("t4_sw_a", SZ_W, 32'h100, 32'hDEADBEEF, 1'b0);
        ld("t4_b", SZ_W, 32'h200, 1'b0, mdl(32'h200, SZ_W));
        ld("t4_c", SZ_W, 32'h300, 1'b0, mdl(32'h300, SZ_W));
        ld("t4_d", SZ_W, 32'h400, 1'b0, mdl(32'h400, SZ_W));
        for (int i = 0; i < 4; i++) exp_wb[i] = word_at(32'h100 + 32'(4 * i));
        clear_log();
        ld("t4_e", SZ_W, 32'h504, 1'b0, mdl(32'h504, SZ_W));
        check("t4_nbeats", beat_addr_q.size(), 32'd8);
        check_line("t4_wb", 0, 1'b1, 32'h100);
        check_line("t4_refill", 4, 1'b0, 32'h500);
        for (int i = 0; i < 4; i++)
            if (i < beat_data_q.size()) check("t4_wb_data", beat_data_q[i], exp_wb[i]);
        check("t4_mem_word", mem_rd(32'h100), 32'hDEADBEEF);
        ld("t4_a_back", SZ_W, 32'h100, 1'b0, 32'hDEADBEEF);

        // T5 stalled memory with cpu_req held high
        do_reset();
        stall = 10;
        clear_log();
        n0 = ready_cnt;
        do_req("t5_stall", 1'b0, SZ_W, 32'h204, 32'h0, 1'b0, mdl(32'h204, SZ_W), 1'b1, lat);
        repeat (4) @(negedge clk);
        #1;
        check("t5_once", ready_cnt - n0, 32'd1);
        check("t5_nbeats", beat_addr_q.size(), 32'd4);
        check_line("t5_refill", 0, 1'b0, 32'h200);
        stall = 0;

        // T6 reset during the second refill beat
        do_reset();
        stall = 3;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_u_b_h_w = SZ_W; cpu_addr = 32'h304;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 200 && beat_addr_q.size() < 1; i++) @(negedge clk);
        check("t6_beat1_seen", beat_addr_q.size(), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t6_req_pre", {31'b0, mem_req}, 32'd1);
        check("t6_addr_pre", mem_addr, 32'h304);
        #2 rst = 1'b1;
        #1 check("t6_req_drop", {31'b0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend.delete();
        sb_q.delete();
        stall = 0;
        clear_log();
        ld("t6_reload", SZ_W, 32'h304, 1'b0, mdl(32'h304, SZ_W));
        check("t6_nbeats", beat_addr_q.size(), 32'd4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
